// File: rtl/warp_register_file.sv
// Banked per-warp register file: two registered operand read ports, one lane-masked
// write port with write-first bypass, generated read-only specials and a clear sequencer.
module warp_register_file #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_WARPS  = 4,
  parameter  int WARP_SIZE  = 8,
  parameter  int NUM_REGS   = 16,
  localparam int WARP_W     = $clog2(NUM_WARPS),
  localparam int REG_W      = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 launch,
  input  logic [DATA_WIDTH-1:0]                block_idx_in,
  input  logic [DATA_WIDTH-1:0]                block_dim_in,
  output logic                                 ready,
  input  logic                                 rd_en,
  input  logic [WARP_W-1:0]                    rd_warp,
  input  logic [REG_W-1:0]                     rs1_addr,
  input  logic [REG_W-1:0]                     rs2_addr,
  output logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] rs1_data,
  output logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] rs2_data,
  output logic                                 rd_valid,
  input  logic                                 wr_en,
  input  logic [WARP_W-1:0]                    wr_warp,
  input  logic [REG_W-1:0]                     wr_addr,
  input  logic [WARP_SIZE-1:0]                 wr_mask,
  input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] wr_data,
  output logic                                 wr_err
);

  localparam int               NUM_GPRS  = NUM_REGS - 3;
  localparam logic [REG_W-1:0] GPR_LAST  = REG_W'(NUM_REGS - 4);
  localparam logic [REG_W-1:0] SPEC_TID  = REG_W'(NUM_REGS - 3);
  localparam logic [REG_W-1:0] SPEC_BIDX = REG_W'(NUM_REGS - 2);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                                 state_q, state_d;
  logic [REG_W-1:0]                       clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]                  block_idx_q, block_idx_d;
  logic [DATA_WIDTH-1:0]                  block_dim_q, block_dim_d;
  logic                                   ready_q, ready_d;
  logic                                   rd_valid_q, rd_valid_d;
  logic                                   wr_err_q, wr_err_d;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]   rs1_q, rs1_d;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]   rs2_q, rs2_d;
  logic [NUM_WARPS-1:0][WARP_SIZE-1:0][NUM_GPRS-1:0][DATA_WIDTH-1:0] gpr_q, gpr_d;

  // Operand for one lane of rd_warp: GPR with write-first bypass, or a generated special.
  function automatic logic [DATA_WIDTH-1:0] lane_operand(input logic [REG_W-1:0] addr,
                                                         input int lane);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (addr <= GPR_LAST) begin
      v = gpr_q[rd_warp][lane][addr];
      if (wr_en && (wr_warp == rd_warp) && (wr_addr == addr) && wr_mask[lane])
        v = wr_data[lane];
    end else if (addr == SPEC_TID) begin
      v = DATA_WIDTH'(rd_warp) * DATA_WIDTH'(WARP_SIZE) + DATA_WIDTH'(lane);
    end else if (addr == SPEC_BIDX) begin
      v = block_idx_q;
    end else begin
      v = block_dim_q;
    end
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    block_idx_d = block_idx_q;
    block_dim_d = block_dim_q;
    gpr_d       = gpr_q;
    rd_valid_d  = 1'b0;
    wr_err_d    = 1'b0;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;

    case (state_q)
      CLEAR: begin
        if (launch) begin
          block_idx_d = block_idx_in;
          block_dim_d = block_dim_in;
          clr_cnt_d   = '0;
        end else begin
          for (int w = 0; w < NUM_WARPS; w++)
            for (int l = 0; l < WARP_SIZE; l++)
              gpr_d[w][l][clr_cnt_q] = '0;
          if (clr_cnt_q == GPR_LAST) begin
            state_d   = READY;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      READY: begin
        // A launch takes priority and drops any coincident read or write.
        if (launch) begin
          block_idx_d = block_idx_in;
          block_dim_d = block_dim_in;
          clr_cnt_d   = '0;
          state_d     = CLEAR;
        end else begin
          if (wr_en) begin
            if (wr_addr > GPR_LAST) begin
              wr_err_d = 1'b1;
            end else begin
              for (int l = 0; l < WARP_SIZE; l++)
                if (wr_mask[l]) gpr_d[wr_warp][l][wr_addr] = wr_data[l];
            end
          end
          if (rd_en) begin
            rd_valid_d = 1'b1;
            for (int l = 0; l < WARP_SIZE; l++) begin
              rs1_d[l] = lane_operand(rs1_addr, l);
              rs2_d[l] = lane_operand(rs2_addr, l);
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase

    ready_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      block_idx_q <= '0;
      block_dim_q <= '0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      block_idx_q <= block_idx_d;
      block_dim_q <= block_dim_d;
      ready_q     <= ready_d;
      rd_valid_q  <= rd_valid_d;
      wr_err_q    <= wr_err_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  // Register storage is RAM-like: no reset, zeroed by the clear sequencer instead.
  always_ff @(posedge clk) begin
    gpr_q <= gpr_d;
  end

  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;

endmodule

// File: tb/tb_warp_register_file.sv
// Directed testbench for warp_register_file with hand-computed expected values.
module tb_warp_register_file;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int WS = 8;
  localparam int NR = 16;
  localparam int WW = $clog2(NW);
  localparam int RW = $clog2(NR);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  launch = 1'b0;
  logic [DW-1:0]         blockIdxIn = '0;
  logic [DW-1:0]         blockDimIn = '0;
  logic                  ready;
  logic                  rdEn = 1'b0;
  logic [WW-1:0]         rdWarp = '0;
  logic [RW-1:0]         rs1Addr = '0;
  logic [RW-1:0]         rs2Addr = '0;
  logic [WS-1:0][DW-1:0] rs1Data;
  logic [WS-1:0][DW-1:0] rs2Data;
  logic                  rdValid;
  logic                  wrEn = 1'b0;
  logic [WW-1:0]         wrWarp = '0;
  logic [RW-1:0]         wrAddr = '0;
  logic [WS-1:0]         wrMask = '0;
  logic [WS-1:0][DW-1:0] wrData = '0;
  logic                  wrErr;

  int vecCount  = 0;
  int missCount = 0;

  warp_register_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .WARP_SIZE(WS), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .launch(launch),
    .block_idx_in(blockIdxIn), .block_dim_in(blockDimIn), .ready(ready),
    .rd_en(rdEn), .rd_warp(rdWarp), .rs1_addr(rs1Addr), .rs2_addr(rs2Addr),
    .rs1_data(rs1Data), .rs2_data(rs2Data), .rd_valid(rdValid),
    .wr_en(wrEn), .wr_warp(wrWarp), .wr_addr(wrAddr), .wr_mask(wrMask),
    .wr_data(wrData), .wr_err(wrErr)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, wait past the edge, then return inputs to idle.
  task automatic applyStimulus(input logic lch, input logic [DW-1:0] bIdx, input logic [DW-1:0] bDim,
                               input logic re, input logic [WW-1:0] rw,
                               input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                               input logic we, input logic [WW-1:0] ww, input logic [RW-1:0] wa,
                               input logic [WS-1:0] wm, input logic [WS-1:0][DW-1:0] wd);
    launch = lch; blockIdxIn = bIdx; blockDimIn = bDim;
    rdEn = re; rdWarp = rw; rs1Addr = a1; rs2Addr = a2;
    wrEn = we; wrWarp = ww; wrAddr = wa; wrMask = wm; wrData = wd;
    @(posedge clk);
    #1;
    launch = 1'b0; rdEn = 1'b0; wrEn = 1'b0; wrMask = '0; wrData = '0;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic doWrite(input logic [WW-1:0] ww, input logic [RW-1:0] wa,
                         input logic [WS-1:0] wm, input logic [WS-1:0][DW-1:0] wd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, ww, wa, wm, wd);
  endtask

  task automatic doRead(input logic [WW-1:0] rw, input logic [RW-1:0] a1, input logic [RW-1:0] a2);
    applyStimulus(0, 0, 0, 1, rw, a1, a2, 0, 0, 0, 0, '0);
  endtask

  task automatic doLaunch(input logic [DW-1:0] bIdx, input logic [DW-1:0] bDim);
    applyStimulus(1, bIdx, bDim, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!ready && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  function automatic logic [127:0] splat(input logic [DW-1:0] v);
    return {WS{v}};
  endfunction

  initial begin
    int cycles;
    logic [WS-1:0][DW-1:0] expVec;
    logic [WS-1:0][DW-1:0] lanesVec;

    #2;
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_rd_valid", rdValid, 0);
    checkOutput("reset_rs1", rs1Data, 0);
    checkOutput("reset_rs2", rs2Data, 0);
    checkOutput("reset_wr_err", wrErr, 0);
    #20 reset = 1'b1;

    waitReady(cycles);
    checkOutput("clear_after_reset_cycles", cycles, 13);

    doRead(3, 0, 12);
    checkOutput("read_w3_valid", rdValid, 1);
    checkOutput("read_w3_r0", rs1Data, 0);
    checkOutput("read_w3_r12", rs2Data, 0);
    idleCycle();
    checkOutput("rd_valid_drops", rdValid, 0);

    for (int i = 0; i < WS; i++) lanesVec[i] = DW'(16'h100 + i);
    doWrite(1, 5, 8'b1010_0101, lanesVec);
    checkOutput("valid_write_no_err", wrErr, 0);
    doRead(1, 5, 5);
    for (int i = 0; i < WS; i++) expVec[i] = (i == 0 || i == 2 || i == 5 || i == 7) ? DW'(16'h100 + i) : '0;
    checkOutput("masked_write_r5", rs1Data, expVec);

    doWrite(2, 4, 8'hFF, splat(16'h4444));
    applyStimulus(0, 0, 0, 1, 2, 3, 4, 1, 2, 3, 8'hFF, splat(16'hBEEF));
    checkOutput("bypass_rs1_full", rs1Data, splat(16'hBEEF));
    checkOutput("bypass_rs2_old", rs2Data, splat(16'h4444));
    applyStimulus(0, 0, 0, 1, 2, 4, 3, 1, 2, 3, 8'h0F, splat(16'h1234));
    expVec = {{4{16'hBEEF}}, {4{16'h1234}}};
    checkOutput("bypass_rs2_partial", rs2Data, expVec);
    checkOutput("bypass_rs1_other", rs1Data, splat(16'h4444));
    doRead(2, 3, 3);
    checkOutput("partial_write_stored", rs1Data, expVec);

    doLaunch(16'd7, 16'd32);
    checkOutput("launch_ready_low", ready, 0);
    waitReady(cycles);
    checkOutput("clear_after_launch_cycles", cycles, 13);
    doRead(2, 13, 14);
    for (int i = 0; i < WS; i++) expVec[i] = DW'(16 + i);
    checkOutput("special_tid_w2", rs1Data, expVec);
    checkOutput("special_block_idx", rs2Data, splat(16'd7));
    doRead(2, 15, 3);
    checkOutput("special_block_dim", rs1Data, splat(16'd32));
    checkOutput("cleared_by_launch", rs2Data, 0);

    doWrite(2, 14, 8'hFF, splat(16'hDEAD));
    checkOutput("wr_err_r14", wrErr, 1);
    doWrite(2, 15, 8'hFF, splat(16'hDEAD));
    checkOutput("wr_err_r15", wrErr, 1);
    doRead(2, 14, 15);
    checkOutput("wr_err_clears", wrErr, 0);
    checkOutput("r14_unchanged", rs1Data, splat(16'd7));
    checkOutput("r15_unchanged", rs2Data, splat(16'd32));
    doWrite(2, 2, 8'h00, splat(16'hAAAA));
    checkOutput("zero_mask_no_err", wrErr, 0);
    doRead(2, 2, 2);
    checkOutput("zero_mask_no_write", rs1Data, 0);

    doWrite(0, 0, 8'hFF, splat(16'h00C3));
    doRead(0, 0, 0);
    checkOutput("fill_r0", rs1Data, splat(16'h00C3));
    applyStimulus(1, 16'd9, 16'd64, 1, 0, 0, 0, 1, 0, 14, 8'hFF, splat(16'h1111));
    checkOutput("launch_wins_rd", rdValid, 0);
    checkOutput("launch_wins_wr", wrErr, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, 14, 8'hFF, splat(16'h2222));
    checkOutput("clear_no_wr_err", wrErr, 0);
    checkOutput("clear_no_rd_valid", rdValid, 0);
    for (int i = 0; i < 3; i++) idleCycle();
    doLaunch(16'd5, 16'd48);
    waitReady(cycles);
    checkOutput("relaunch_ready_low_total", 5 + cycles, 18);
    doRead(0, 0, 14);
    checkOutput("r0_cleared", rs1Data, 0);
    checkOutput("relatched_block_idx", rs2Data, splat(16'd5));

    doWrite(0, 1, 8'hFF, splat(16'h5555));
    doRead(0, 1, 1);
    checkOutput("pre_reset_read", rs1Data, splat(16'h5555));
    rdEn = 1'b1; rdWarp = 0; rs1Addr = 1; rs2Addr = 1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    rdEn = 1'b0;
    checkOutput("midreset_rd_valid", rdValid, 0);
    checkOutput("midreset_rs1", rs1Data, 0);
    checkOutput("midreset_rs2", rs2Data, 0);
    checkOutput("midreset_ready", ready, 0);
    #10 reset = 1'b1;
    waitReady(cycles);
    checkOutput("clear_after_midreset_cycles", cycles, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
